pkt_dispatcher: RTL and testbench
=================================

Name: pkt_dispatcher

Overview:
- Ingress-side mirror of the egress arbiter: one AXI4-Stream input fans out to C_NUM_QUEUES AXI4-Stream output ports.
- Routing is per packet. The destination is a one-hot field in tuser, sampled on the first beat and held until tlast.
- Multicast and drop are supported.
- Each output has its own 16-entry fallthrough FIFO, so one slow port stalls only packets that target it.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, tuser width; tuser is passed through unchanged.
- C_NUM_QUEUES, 4, number of output ports; the port list is fixed at 4.
- C_NUM_QUEUES_WIDTH, 2, log2(C_NUM_QUEUES).
- C_DST_LSB, 24, LSB of the one-hot destination field tuser[C_DST_LSB +: C_NUM_QUEUES].

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  input byte enables.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata; carries the destination field.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata_k  out  C_AXIS_DATA_WIDTH  port k data, k=0..3.
- m_axis_tkeep_k  out  C_AXIS_DATA_WIDTH/8  port k byte enables.
- m_axis_tuser_k  out  C_AXIS_TUSER_WIDTH  port k metadata.
- m_axis_tvalid_k  out  1  port k valid.
- m_axis_tlast_k  out  1  port k last.
- m_axis_tready_k  in  1  port k ready.
- drop_cnt  out  32  saturating count of dropped packets.

Behaviour:
- Reset, while aresetn=0:
  - state=IDLE, dst_reg=0, drop_cnt=0, all FIFOs flushed.
  - all m_axis_tvalid_k=0 and s_axis_tready=0; s_axis_tready is gated by aresetn.
- dst_cur: in IDLE, dst_cur = s_axis_tuser[C_DST_LSB +: C_NUM_QUEUES]; otherwise dst_cur = dst_reg.
- s_axis_tready:
  - 1 if state=DROP, or state=IDLE with dst_cur=0.
  - Otherwise 1 only if no destination bit k in dst_cur has nearly_full[k] set (AND over selected ports).
  - Every selected FIFO is written on the same beat; no partial multicast writes ever occur.
- Accept: a beat is accepted when s_axis_tvalid & s_axis_tready. On accept, wr_en[k] = dst_cur[k] for non-drop states, and the FIFO word is {tdata, tuser, tkeep, tlast}.
- State machine (IDLE, FWD, DROP):
  - IDLE, accept with dst_cur≠0 and !tlast: dst_reg<=dst_cur, go to FWD.
  - IDLE, accept with dst_cur≠0 and tlast: single-beat packet, stay in IDLE.
  - IDLE, accept with dst_cur=0: drop_cnt++ (saturate at 0xFFFFFFFF). Go to DROP if !tlast, else stay in IDLE. Nothing is written.
  - FWD: tuser on later beats is ignored for routing. Accept with tlast: go to IDLE.
  - DROP: consumes beats at 1/cycle with no writes. Accept with tlast: go to IDLE.
- Output side, per port k, independent:
  - m_axis_tvalid_k = ~empty[k]; m_axis_*_k = FIFO head.
  - rd_en[k] = m_axis_tvalid_k & m_axis_tready_k.
  - tvalid does not depend on tready; AXIS-compliant, unlike the egress arbiter's gated tvalid.
- Latency: a beat accepted in cycle N is visible on m_axis_*_k in cycle N+1. Throughput is 1 beat/cycle when outputs are not back-pressured.
- Boundaries:
  - nearly_full asserts with 1 free slot left. A write on the cycle nearly_full rises is legal, so FIFOs never overflow.
  - tvalid low mid-packet: state is held.
  - Read and write on the same FIFO in the same cycle are both honoured.
  - Reset mid-packet: partial packets in the FIFOs are discarded; the next input beat is treated as a first beat.

Decomposition:
- Package pkt_dispatcher_pkg holds: state encodings IDLE=2'd0, FWD=2'd1, DROP=2'd2; FIFO_DEPTH_BITS=4; DROP_CNT_W=32.
- Sub-module: the existing fallthrough_small_fifo, instantiated once per port in a generate loop, WIDTH = data + keep + user + 1.
- Top level contains the FSM, the ready logic and drop_cnt (roughly 200 lines).

Test Plan:
- Unicast: 3-beat packet with tuser dst=4'b0100, all m_axis_tready high -> beats appear only on port 2, at cycles N+1..N+3, tlast on the 3rd beat; ports 0, 1, 3 keep tvalid=0.
- Multicast: 2-beat packet with dst=4'b1011 -> identical data/keep/user/last on ports 0, 1 and 3; port 2 stays idle; drop_cnt=0.
- Drop: 4-beat packet with dst=0, followed by 1-beat packet with dst=4'b0001 -> s_axis_tready=1 for all 4 dropped beats and drop_cnt=1; the second packet reaches port 0.
- Backpressure: m_axis_tready_1=0, stream 20 beats to dst=4'b0010 -> s_axis_tready falls once port 1 has 15 entries, no overflow. Then traffic to dst=4'b0001 stays blocked until tready_1 rises; after that all 20 beats drain in order.
- Mid-packet tuser change: first beat dst=4'b0001, second beat tuser dst=4'b1000 -> both beats go to port 0.
- Reset mid-FWD: deassert aresetn for 1 cycle after beat 2 of 5 -> all m_axis_tvalid_k=0, drop_cnt=0, state=IDLE. The next beat with dst=4'b0100 is routed as a new packet to port 2.

Source files
------------

// File: rtl/pkt_dispatcher_pkg.sv
// Shared types and constants for the ingress packet dispatcher.
package pkt_dispatcher_pkg;

  // Ingress packet state: waiting for a first beat, forwarding, or discarding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int FIFO_DEPTH_BITS = 4;
  localparam int DROP_CNT_W      = 32;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head word is on dout whenever empty=0.
// nearly_full is raised while only one free slot remains.
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0]   FULL_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0]   NF_CNT   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE  = (MAX_DEPTH_BITS+1)'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_reg;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_reg;
  logic [MAX_DEPTH_BITS:0]   count_reg;
  logic                      wr_ok;
  logic                      rd_ok;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign wr_ok       = wr_en && (count_reg != FULL_CNT);
  assign rd_ok       = rd_en && (count_reg != '0);
  assign dout        = mem[rd_ptr_reg];
  assign empty       = (count_reg == '0);
  assign nearly_full = (count_reg >= NF_CNT);

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous read and write leave the count unchanged.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pkt_dispatcher.sv
// Ingress dispatcher: one AXI4-Stream input fanned out per packet to four
// output ports through per-port fallthrough FIFOs, with multicast and drop.
module pkt_dispatcher
  import pkt_dispatcher_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_QUEUES       = 4,
  parameter int C_NUM_QUEUES_WIDTH = 2,
  parameter int C_DST_LSB          = 24
) (
  input  logic                            axis_clk,
  input  logic                            aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_0,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                            m_axis_tvalid_0,
  output logic                            m_axis_tlast_0,
  input  logic                            m_axis_tready_0,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_1,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                            m_axis_tvalid_1,
  output logic                            m_axis_tlast_1,
  input  logic                            m_axis_tready_1,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_2,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                            m_axis_tvalid_2,
  output logic                            m_axis_tlast_2,
  input  logic                            m_axis_tready_2,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep_3,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                            m_axis_tvalid_3,
  output logic                            m_axis_tlast_3,
  input  logic                            m_axis_tready_3,
  output logic [DROP_CNT_W-1:0]           drop_cnt
);

  localparam int DW     = C_AXIS_DATA_WIDTH;
  localparam int KW     = C_AXIS_DATA_WIDTH / 8;
  localparam int UW     = C_AXIS_TUSER_WIDTH;
  localparam int NQ     = C_NUM_QUEUES;
  localparam int FIFO_W = DW + UW + KW + 1;

  state_t                  state_reg;
  logic [NQ-1:0]           dst_reg;
  logic [DROP_CNT_W-1:0]   drop_cnt_reg;

  logic [NQ-1:0]           dst_cur;
  logic [NQ-1:0]           nearly_full;
  logic [NQ-1:0]           empty;
  logic [NQ-1:0]           wr_en;
  logic [NQ-1:0]           rd_en;
  logic [NQ-1:0]           m_ready;
  logic                    accept;
  logic                    fifo_srst;
  logic [FIFO_W-1:0]       din;
  logic [FIFO_W-1:0]       dout [NQ];
  logic [DW-1:0]           f_data [NQ];
  logic [KW-1:0]           f_keep [NQ];
  logic [UW-1:0]           f_user [NQ];
  logic [NQ-1:0]           f_last;

  // Routing is taken from tuser only on a first beat; later beats reuse the latched mask.
  assign dst_cur = (state_reg == IDLE) ? s_axis_tuser[C_DST_LSB +: NQ] : dst_reg;

  // Accept only when every targeted FIFO has room, so a multicast beat lands everywhere or nowhere.
  assign s_axis_tready = aresetn &&
                         ((state_reg == DROP) || (dst_cur == '0) || ((dst_cur & nearly_full) == '0));
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign wr_en     = (accept && (state_reg != DROP)) ? dst_cur : '0;
  assign din       = {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};
  assign fifo_srst = !aresetn;
  assign m_ready   = {m_axis_tready_3, m_axis_tready_2, m_axis_tready_1, m_axis_tready_0};
  assign drop_cnt  = drop_cnt_reg;

  // One FIFO per output port; each port drains independently.
  generate
    for (genvar gi = 0; gi < (1 << C_NUM_QUEUES_WIDTH); gi++) begin : g_port
      fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
      ) u_fifo (
        .clk         (axis_clk),
        .srst        (fifo_srst),
        .din         (din),
        .wr_en       (wr_en[gi]),
        .rd_en       (rd_en[gi]),
        .dout        (dout[gi]),
        .nearly_full (nearly_full[gi]),
        .empty       (empty[gi])
      );
      assign rd_en[gi]  = !empty[gi] && m_ready[gi];
      assign f_data[gi] = dout[gi][FIFO_W-1 -: DW];
      assign f_user[gi] = dout[gi][KW+1 +: UW];
      assign f_keep[gi] = dout[gi][1 +: KW];
      assign f_last[gi] = dout[gi][0];
    end
  endgenerate

  assign m_axis_tdata_0  = f_data[0];
  assign m_axis_tkeep_0  = f_keep[0];
  assign m_axis_tuser_0  = f_user[0];
  assign m_axis_tlast_0  = f_last[0];
  assign m_axis_tvalid_0 = !empty[0];
  assign m_axis_tdata_1  = f_data[1];
  assign m_axis_tkeep_1  = f_keep[1];
  assign m_axis_tuser_1  = f_user[1];
  assign m_axis_tlast_1  = f_last[1];
  assign m_axis_tvalid_1 = !empty[1];
  assign m_axis_tdata_2  = f_data[2];
  assign m_axis_tkeep_2  = f_keep[2];
  assign m_axis_tuser_2  = f_user[2];
  assign m_axis_tlast_2  = f_last[2];
  assign m_axis_tvalid_2 = !empty[2];
  assign m_axis_tdata_3  = f_data[3];
  assign m_axis_tkeep_3  = f_keep[3];
  assign m_axis_tuser_3  = f_user[3];
  assign m_axis_tlast_3  = f_last[3];
  assign m_axis_tvalid_3 = !empty[3];

  // Packet FSM: latches the destination on the first beat and counts packets with no destination.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      dst_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (dst_cur != '0) begin
              if (!s_axis_tlast) begin
                dst_reg   <= dst_cur;
                state_reg <= FWD;
              end
            end else begin
              if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
              if (!s_axis_tlast) state_reg <= DROP;
            end
          end
        end
        FWD, DROP: begin
          if (accept && s_axis_tlast) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Randomised bench for pkt_dispatcher with a queue-based reference model.
module tb_pkt_dispatcher;

  localparam int DW  = 256;
  localparam int KW  = 32;
  localparam int UW  = 128;
  localparam int NQ  = 4;
  localparam int LSB = 24;
  localparam int W   = DW + UW + KW + 1;

  typedef logic [W-1:0] word_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [NQ-1:0] m_tready = '1;
  logic [DW-1:0] m_tdata [NQ];
  logic [KW-1:0] m_tkeep [NQ];
  logic [UW-1:0] m_tuser [NQ];
  logic [NQ-1:0] m_tvalid;
  logic [NQ-1:0] m_tlast;
  logic [31:0]   drop_cnt;

  pkt_dispatcher dut (
    .axis_clk        (clk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tuser    (s_tuser),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tready   (s_tready),
    .m_axis_tdata_0  (m_tdata[0]),
    .m_axis_tkeep_0  (m_tkeep[0]),
    .m_axis_tuser_0  (m_tuser[0]),
    .m_axis_tvalid_0 (m_tvalid[0]),
    .m_axis_tlast_0  (m_tlast[0]),
    .m_axis_tready_0 (m_tready[0]),
    .m_axis_tdata_1  (m_tdata[1]),
    .m_axis_tkeep_1  (m_tkeep[1]),
    .m_axis_tuser_1  (m_tuser[1]),
    .m_axis_tvalid_1 (m_tvalid[1]),
    .m_axis_tlast_1  (m_tlast[1]),
    .m_axis_tready_1 (m_tready[1]),
    .m_axis_tdata_2  (m_tdata[2]),
    .m_axis_tkeep_2  (m_tkeep[2]),
    .m_axis_tuser_2  (m_tuser[2]),
    .m_axis_tvalid_2 (m_tvalid[2]),
    .m_axis_tlast_2  (m_tlast[2]),
    .m_axis_tready_2 (m_tready[2]),
    .m_axis_tdata_3  (m_tdata[3]),
    .m_axis_tkeep_3  (m_tkeep[3]),
    .m_axis_tuser_3  (m_tuser[3]),
    .m_axis_tvalid_3 (m_tvalid[3]),
    .m_axis_tlast_3  (m_tlast[3]),
    .m_axis_tready_3 (m_tready[3]),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: expected contents of every output port, packet context, drop total.
  word_t       q [NQ][$];
  bit          in_pkt   = 1'b0;
  bit          pkt_drop = 1'b0;
  logic [3:0]  pkt_dst  = '0;
  logic [31:0] exp_drop = '0;
  bit          started  = 1'b0;
  bit          rand_rdy = 1'b0;
  int          recv_cnt [NQ];
  int          dut_cnt  [NQ];

  initial begin
    for (int k = 0; k < NQ; k++) begin
      recv_cnt[k] = 0;
      dut_cnt[k]  = 0;
    end
  end

  task automatic chk(input string nm, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // The input is ready unless a port targeted by the current packet holds 15 or more words.
  function automatic bit exp_ready();
    logic [3:0] d;
    if (!aresetn) return 1'b0;
    if (in_pkt && pkt_drop) return 1'b1;
    d = in_pkt ? pkt_dst : s_tuser[LSB +: 4];
    if (d == '0) return 1'b1;
    for (int k = 0; k < NQ; k++)
      if (d[k] && q[k].size() >= 15) return 1'b0;
    return 1'b1;
  endfunction

  // Model update at each clock edge from the pre-edge inputs.
  always @(posedge clk) begin
    bit         acc;
    logic [3:0] d;
    word_t      w;
    if (!aresetn) begin
      for (int k = 0; k < NQ; k++) q[k].delete();
      in_pkt   = 1'b0;
      pkt_drop = 1'b0;
      exp_drop = '0;
      started  = 1'b1;
    end else begin
      acc = s_tvalid && exp_ready();
      for (int k = 0; k < NQ; k++) begin
        if (m_tready[k] && q[k].size() > 0) begin
          void'(q[k].pop_front());
          recv_cnt[k]++;
        end
        if (m_tready[k] && m_tvalid[k]) dut_cnt[k]++;
      end
      if (acc) begin
        w = {s_tdata, s_tuser, s_tkeep, s_tlast};
        if (!in_pkt) begin
          d = s_tuser[LSB +: 4];
          if (d == '0) begin
            if (exp_drop != 32'hFFFF_FFFF) exp_drop = exp_drop + 1;
            pkt_drop = 1'b1;
          end else begin
            pkt_drop = 1'b0;
            pkt_dst  = d;
          end
          in_pkt = !s_tlast;
        end else if (s_tlast) begin
          in_pkt = 1'b0;
        end
        if (!pkt_drop)
          for (int k = 0; k < NQ; k++)
            if (pkt_dst[k]) q[k].push_back(w);
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("s_tready", word_t'(s_tready), word_t'(exp_ready()));
      chk("drop_cnt", word_t'(drop_cnt), word_t'(exp_drop));
      for (int k = 0; k < NQ; k++) begin
        chk($sformatf("tvalid_%0d", k), word_t'(m_tvalid[k]), word_t'(q[k].size() > 0));
        if (q[k].size() > 0 && m_tvalid[k])
          chk($sformatf("head_%0d", k), {m_tdata[k], m_tuser[k], m_tkeep[k], m_tlast[k]}, q[k][0]);
      end
    end
  end

  // Random per-port back-pressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_tready = 4'($urandom);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Offer one beat and hold it until the handshake completes (bounded).
  task automatic send_beat(input logic [3:0] dst, input bit last);
    bit acc;
    int n;
    for (int i = 0; i < DW / 32; i++) s_tdata[i*32 +: 32] = $urandom;
    for (int i = 0; i < UW / 32; i++) s_tuser[i*32 +: 32] = $urandom;
    s_tuser[LSB +: 4] = dst;
    s_tkeep  = $urandom;
    s_tlast  = last;
    s_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 2000);
    s_tvalid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL handshake: got no s_tready after %0d cycles expected acceptance", n);
    end
    $display("beat dst=%b last=%0b cycles=%0d", dst, last, n);
  endtask

  // A packet: first beat carries dst, later beats carry later_dst (which must be ignored).
  task automatic send_pkt(input logic [3:0] dst, input int len, input logic [3:0] later_dst, input bit gaps);
    for (int b = 0; b < len; b++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        @(posedge clk);
        #1;
      end
      send_beat((b == 0) ? dst : later_dst, b == len - 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (n >= 1000) begin
      bad++;
      $display("FAIL drain: got outputs still pending expected empty");
    end
  endtask

  int b0, b1, b2, b3;

  task automatic snap();
    b0 = dut_cnt[0]; b1 = dut_cnt[1]; b2 = dut_cnt[2]; b3 = dut_cnt[3];
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", word_t'(s_tready), word_t'(0));
    chk("rst_tvalid", word_t'(m_tvalid), word_t'(0));
    chk("rst_drop", word_t'(drop_cnt), word_t'(0));
    @(posedge clk);
    #1;
    aresetn = 1'b1;

    // Unicast to port 2
    snap();
    send_pkt(4'b0100, 3, 4'b0100, 1'b0);
    wait_drain();
    chk("uni_p2", word_t'(dut_cnt[2] - b2), word_t'(3));
    chk("uni_p0", word_t'(dut_cnt[0] - b0), word_t'(0));
    chk("uni_p13", word_t'((dut_cnt[1] - b1) + (dut_cnt[3] - b3)), word_t'(0));
    chk("uni_model", word_t'(recv_cnt[2]), word_t'(3));

    // Multicast to ports 0,1,3
    snap();
    send_pkt(4'b1011, 2, 4'b1011, 1'b0);
    wait_drain();
    chk("mc_p0", word_t'(dut_cnt[0] - b0), word_t'(2));
    chk("mc_p1", word_t'(dut_cnt[1] - b1), word_t'(2));
    chk("mc_p3", word_t'(dut_cnt[3] - b3), word_t'(2));
    chk("mc_p2", word_t'(dut_cnt[2] - b2), word_t'(0));
    chk("mc_drop", word_t'(drop_cnt), word_t'(0));

    // Drop a 4-beat packet, then a single beat to port 0
    snap();
    send_pkt(4'b0000, 4, 4'b1111, 1'b0);
    send_pkt(4'b0001, 1, 4'b0001, 1'b0);
    wait_drain();
    chk("drop_cnt1", word_t'(drop_cnt), word_t'(1));
    chk("drop_model", word_t'(exp_drop), word_t'(1));
    chk("drop_p0", word_t'(dut_cnt[0] - b0), word_t'(1));
    chk("drop_p123", word_t'((dut_cnt[1] - b1) + (dut_cnt[2] - b2) + (dut_cnt[3] - b3)), word_t'(0));

    // Mid-packet tuser change is ignored
    snap();
    send_pkt(4'b0001, 2, 4'b1000, 1'b0);
    wait_drain();
    chk("mid_p0", word_t'(dut_cnt[0] - b0), word_t'(2));
    chk("mid_p3", word_t'(dut_cnt[3] - b3), word_t'(0));

    // Back-pressure on port 1
    snap();
    m_tready[1] = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(4'b0010, 1'b1);
        send_beat(4'b0001, 1'b1);
      end
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_tready", word_t'(s_tready), word_t'(0));
        chk("bp_fill", word_t'(q[1].size()), word_t'(15));
        chk("bp_p1", word_t'(dut_cnt[1] - b1), word_t'(0));
        chk("bp_p0_blocked", word_t'(dut_cnt[0] - b0), word_t'(0));
        @(posedge clk);
        #1;
        m_tready[1] = 1'b1;
      end
    join
    wait_drain();
    chk("bp_p1_all", word_t'(dut_cnt[1] - b1), word_t'(20));
    chk("bp_p0", word_t'(dut_cnt[0] - b0), word_t'(1));

    // Randomised traffic with random back-pressure and gaps
    rand_rdy = 1'b1;
    for (int p = 0; p < 60; p++)
      send_pkt(4'($urandom), $urandom_range(1, 5), 4'($urandom), 1'b1);
    rand_rdy = 1'b0;
    m_tready = '1;
    wait_drain();

    // Reset in the middle of a forwarded packet
    m_tready = 4'b1110;
    send_pkt(4'b0000, 1, 4'b0000, 1'b0);
    snap();
    send_beat(4'b0001, 1'b0);
    send_beat(4'b0001, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    chk("mr_tready_low", word_t'(s_tready), word_t'(0));
    @(negedge clk);
    chk("mr_tvalid", word_t'(m_tvalid), word_t'(0));
    chk("mr_drop", word_t'(drop_cnt), word_t'(0));
    aresetn  = 1'b1;
    m_tready = '1;
    @(posedge clk);
    #1;
    snap();
    send_beat(4'b0100, 1'b1);
    wait_drain();
    chk("mr_p2", word_t'(dut_cnt[2] - b2), word_t'(1));
    chk("mr_p0", word_t'(dut_cnt[0] - b0), word_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
